// File: rtl/fcsr_unit.sv
// Floating-point control/status register block.
// Accumulates sticky exception flags from the FP execute units and holds the
// dynamic rounding mode. Serves CSR accesses to fflags (0x001), frm (0x002)
// and fcsr (0x003), and resolves the effective rounding mode for each issuing
// FP instruction.
module fcsr_unit #(
  parameter logic [2:0] RESET_FRM = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fp_valid,
  input  logic [4:0]  fp_flags,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic        csr_rvalid,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic [2:0]  instr_rm,
  output logic [2:0]  rm_eff,
  output logic        rm_illegal,
  output logic [2:0]  frm_out,
  output logic [4:0]  fflags_out
);

  localparam logic [11:0] AddrFflags = 12'h001;
  localparam logic [11:0] AddrFrm    = 12'h002;
  localparam logic [11:0] AddrFcsr   = 12'h003;

  localparam logic [1:0] OpRead = 2'b00;
  localparam logic [1:0] OpRw   = 2'b01;
  localparam logic [1:0] OpRs   = 2'b10;
  localparam logic [1:0] OpRc   = 2'b11;

  logic [4:0]  r_fflags;
  logic [2:0]  r_frm;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_illegal;

  logic        w_addr_ok;
  logic        w_wr_fflags;
  logic        w_wr_frm;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic [4:0]  w_fflags_d;
  logic [2:0]  w_frm_d;
  logic        w_unused_new;

  // Decode the target CSR and fetch its pre-edge value.
  always_comb begin
    w_addr_ok   = 1'b1;
    w_wr_fflags = 1'b0;
    w_wr_frm    = 1'b0;
    w_old       = 32'h0;
    unique case (csr_addr)
      AddrFflags: begin
        w_old       = {27'h0, r_fflags};
        w_wr_fflags = csr_en;
      end
      AddrFrm: begin
        w_old    = {29'h0, r_frm};
        w_wr_frm = csr_en;
      end
      AddrFcsr: begin
        w_old       = {24'h0, r_frm, r_fflags};
        w_wr_fflags = csr_en;
        w_wr_frm    = csr_en;
      end
      default: w_addr_ok = 1'b0;
    endcase
  end

  // Apply the CSR operation to the old value; fields are truncated below.
  always_comb begin
    w_new = w_old;
    unique case (csr_op)
      OpRw:    w_new = csr_wdata;
      OpRs:    w_new = w_old | csr_wdata;
      OpRc:    w_new = w_old & ~csr_wdata;
      OpRead:  w_new = w_old;
      default: w_new = w_old;
    endcase
  end

  // Upper operand bits never reach any field.
  assign w_unused_new = ^w_new[31:8];

  // Next-state for the fields; retiring FP flags are OR-ed after any CSR write
  // so that a same-cycle clear never loses them.
  always_comb begin
    w_fflags_d = r_fflags;
    w_frm_d    = r_frm;
    if (w_wr_fflags) w_fflags_d = w_new[4:0];
    if (w_wr_frm) begin
      w_frm_d = (csr_addr == AddrFcsr) ? w_new[7:5] : w_new[2:0];
    end
    if (fp_valid) w_fflags_d = w_fflags_d | fp_flags;
  end

  // Architectural state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fflags <= 5'h0;
      r_frm    <= RESET_FRM;
    end else begin
      r_fflags <= w_fflags_d;
      r_frm    <= w_frm_d;
    end
  end

  // Registered CSR response: one-cycle pulse, zero data when idle or illegal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
      r_illegal <= 1'b0;
    end else begin
      r_rvalid  <= csr_en;
      r_rdata   <= (csr_en && w_addr_ok) ? w_old : 32'h0;
      r_illegal <= csr_en && !w_addr_ok;
    end
  end

  assign csr_rvalid  = r_rvalid;
  assign csr_rdata   = r_rdata;
  assign csr_illegal = r_illegal;
  assign frm_out     = r_frm;
  assign fflags_out  = r_fflags;

  // DYN (3'b111) defers to frm; 101..111 are reserved encodings.
  assign rm_eff     = (instr_rm == 3'b111) ? r_frm : instr_rm;
  assign rm_illegal = (rm_eff >= 3'b101);

endmodule

// File: tb/tb_fcsr_unit.sv
// Self-checking bench for fcsr_unit: directed test-plan steps followed by
// random traffic, all compared against a behavioural model of the CSR state.
module tb_fcsr_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fp_valid = 1'b0;
  logic [4:0]  fp_flags = 5'h0;
  logic        csr_en = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] csr_wdata = 32'h0;
  logic        csr_rvalid;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic [2:0]  instr_rm = 3'b000;
  logic [2:0]  rm_eff;
  logic        rm_illegal;
  logic [2:0]  frm_out;
  logic [4:0]  fflags_out;

  int checks = 0;
  int errors = 0;

  // Model state.
  int m_fflags = 0;
  int m_frm    = 0;

  fcsr_unit #(.RESET_FRM(3'b000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fp_valid   (fp_valid),
    .fp_flags   (fp_flags),
    .csr_en     (csr_en),
    .csr_op     (csr_op),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rvalid (csr_rvalid),
    .csr_rdata  (csr_rdata),
    .csr_illegal(csr_illegal),
    .instr_rm   (instr_rm),
    .rm_eff     (rm_eff),
    .rm_illegal (rm_illegal),
    .frm_out    (frm_out),
    .fflags_out (fflags_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_read(input int addr);
    case (addr)
      1:       return m_fflags;
      2:       return m_frm;
      3:       return m_frm * 32 + m_fflags;
      default: return 0;
    endcase
  endfunction

  // One clock: apply inputs, predict, clock, compare registered outputs.
  task automatic cyc(input logic en, input logic [1:0] op, input logic [11:0] addr,
                     input logic [31:0] wd, input logic fv, input logic [4:0] fl,
                     input string tag);
    int old_v;
    longint nv;
    bit ok;
    int e_rdata;
    csr_en = en; csr_op = op; csr_addr = addr; csr_wdata = wd;
    fp_valid = fv; fp_flags = fl;
    ok = (addr >= 1 && addr <= 3);
    old_v = model_read(int'(addr));
    case (op)
      2'b01:   nv = longint'(wd);
      2'b10:   nv = longint'(old_v) | longint'(wd);
      2'b11:   nv = longint'(old_v) & ~longint'(wd);
      default: nv = longint'(old_v);
    endcase
    e_rdata = (en && ok) ? old_v : 0;
    if (en && ok) begin
      if (addr == 1) m_fflags = int'(nv % 32);
      else if (addr == 2) m_frm = int'(nv % 8);
      else begin
        m_fflags = int'(nv % 32);
        m_frm    = int'((nv / 32) % 8);
      end
    end
    if (fv) m_fflags = m_fflags | int'(fl);
    @(posedge clk); #1;
    chk({tag, ".rvalid"}, {31'h0, csr_rvalid}, {31'h0, en});
    chk({tag, ".rdata"}, csr_rdata, e_rdata);
    chk({tag, ".illegal"}, {31'h0, csr_illegal}, {31'h0, en && !ok});
    chk({tag, ".fflags"}, {27'h0, fflags_out}, m_fflags);
    chk({tag, ".frm"}, {29'h0, frm_out}, m_frm);
    csr_en = 1'b0; fp_valid = 1'b0;
  endtask

  task automatic chk_rm(input logic [2:0] rm, input string tag);
    int e;
    instr_rm = rm;
    #1;
    e = (rm == 3'b111) ? m_frm : int'(rm);
    chk({tag, ".rm_eff"}, {29'h0, rm_eff}, e);
    chk({tag, ".rm_illegal"}, {31'h0, rm_illegal}, (e >= 5) ? 1 : 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".rvalid"}, {31'h0, csr_rvalid}, 0);
    chk({tag, ".rdata"}, csr_rdata, 0);
    chk({tag, ".illegal"}, {31'h0, csr_illegal}, 0);
    chk({tag, ".fflags"}, {27'h0, fflags_out}, 0);
    chk({tag, ".frm"}, {29'h0, frm_out}, 0);
  endtask

  initial begin
    logic [11:0] ra;
    // Reset state.
    #12;
    chk_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    cyc(1, 2'b00, 12'h003, 0, 0, 0, "rd_fcsr0");
    cyc(0, 2'b00, 12'h000, 0, 1, 5'b10000, "fp_nv");
    cyc(0, 2'b00, 12'h000, 0, 1, 5'b00001, "fp_nx");
    cyc(1, 2'b00, 12'h001, 0, 0, 0, "rd_fflags");
    cyc(1, 2'b01, 12'h003, 32'hFFFF_FFE5, 0, 0, "rw_fcsr");
    cyc(1, 2'b00, 12'h002, 0, 0, 0, "rd_frm");
    cyc(1, 2'b11, 12'h001, 32'h4, 0, 0, "rc_fflags");
    cyc(1, 2'b01, 12'h001, 0, 1, 5'b00010, "rw_plus_fp");
    cyc(1, 2'b01, 12'h002, 32'h2, 0, 0, "frm_010");
    chk_rm(3'b111, "dyn_010");
    cyc(1, 2'b10, 12'h002, 32'h5, 0, 0, "frm_rs_101");
    chk_rm(3'b111, "dyn_111");
    cyc(1, 2'b01, 12'h002, 32'h5, 0, 0, "frm_101");
    chk_rm(3'b111, "dyn_101");
    chk_rm(3'b110, "rm_110");
    chk_rm(3'b001, "rm_001");
    cyc(1, 2'b01, 12'h300, 32'hFF, 1, 5'b01000, "illegal_300");
    cyc(0, 2'b00, 12'h000, 0, 0, 0, "idle");
    cyc(1, 2'b00, 12'h003, 0, 0, 0, "rd_after_ill");

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 12'h001;
        1: ra = 12'h002;
        2: ra = 12'h003;
        3: ra = 12'h000;
        default: ra = 12'($urandom);
      endcase
      cyc(1'($urandom), 2'($urandom), ra, $urandom, 1'($urandom), 5'($urandom), "rand");
      chk_rm(3'($urandom), "rand_rm");
    end

    // Reset asserted mid-access: outputs clear immediately, access is dropped.
    cyc(1, 2'b01, 12'h003, 32'hA7, 1, 5'b00100, "pre_reset");
    csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h003; csr_wdata = 32'hFF;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    m_fflags = 0; m_frm = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; csr_en = 1'b0;
    chk_reset_outputs("held_reset");
    cyc(0, 2'b00, 12'h000, 0, 0, 0, "post_reset");
    cyc(1, 2'b00, 12'h003, 0, 0, 0, "rd_post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
